// File: rtl/hazard_controller.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch/jump squash, memory wait freeze.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_count performance counters.
module hazard_controller #(
    parameter int REG_W             = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic [1:0]       mem_op,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             stall,
    output logic             mem_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    typedef enum logic {RUN, LOAD_STALL} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_load_cnt;
    logic [2:0] w_load_cnt_next;
    logic [7:0] r_wait_cnt;
    logic       r_mem_error;

    logic       w_rs_used;
    logic       w_rt_used;
    logic       w_load_use;
    logic       w_busy_raw;
    logic       w_timeout;
    logic       w_mem_busy;
    logic       w_jump;

    assign w_rs_used = (id_opcode != 4'd15);

    always_comb begin
        case (id_opcode)
            4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd12, 4'd13, 4'd14: w_rt_used = 1'b1;
            default:             w_rt_used = 1'b0;
        endcase
    end

    assign w_load_use = ex_mem_to_reg && (ex_write_reg != '0) &&
                        ((w_rs_used && (id_rs == ex_write_reg)) ||
                         (w_rt_used && (id_rt == ex_write_reg)));

    // Once the wait counter hits the limit, the next cycle pretends the access finished.
    assign w_busy_raw = (mem_op != 2'b00) && !mem_ready;
    assign w_timeout  = (r_wait_cnt == 8'(MEM_TIMEOUT));
    assign w_mem_busy = w_busy_raw && !w_timeout;
    assign w_jump     = (id_opcode == 4'd15);

    always_comb begin
        w_state_next    = r_state;
        w_load_cnt_next = r_load_cnt;
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_stall     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_stall    = 1'b0;
        mem_wb_bubble   = 1'b0;
        if (w_mem_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            w_state_next    = RUN;
            w_load_cnt_next = 3'd0;
        end else if (r_state == LOAD_STALL) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (r_load_cnt <= 3'd1) begin
                w_state_next    = RUN;
                w_load_cnt_next = 3'd0;
            end else begin
                w_load_cnt_next = r_load_cnt - 3'd1;
            end
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_state_next    = LOAD_STALL;
                w_load_cnt_next = 3'(LOAD_STALL_CYCLES - 1);
            end
        end else if (w_jump) begin
            if_id_flush = 1'b1;
        end
    end

    assign stall     = pc_stall | id_ex_flush;
    assign mem_error = r_mem_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_load_cnt  <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_error <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_load_cnt <= w_load_cnt_next;
            r_wait_cnt <= w_mem_busy ? (r_wait_cnt + 8'd1) : 8'd0;
            if (w_timeout && w_busy_raw) begin
                r_mem_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (pc_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (if_id_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: two instances (1 and 3 load bubbles) share one stimulus stream.
module tb_hazard_controller;

    localparam logic [7:0] IDLE   = 8'b0000_0000;
    localparam logic [7:0] LSTALL = 8'b1100_1001;
    localparam logic [7:0] FLUSH2 = 8'b0010_1001;
    localparam logic [7:0] FREEZE = 8'b1101_0111;
    localparam logic [7:0] JUMP   = 8'b0010_0000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] id_opcode;
    logic [2:0] id_rs, id_rt;
    logic       ex_mem_to_reg;
    logic [2:0] ex_write_reg;
    logic       ex_branch_taken;
    logic [1:0] mem_op;
    logic       mem_ready;

    logic a_pc, a_ifs, a_iff, a_ides, a_idef, a_ems, a_mwb, a_st, a_err;
    logic b_pc, b_ifs, b_iff, b_ides, b_idef, b_ems, b_mwb, b_st, b_err;
    logic [7:0] d1, d3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_W(3), .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15)) dut1 (
        .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .mem_op(mem_op), .mem_ready(mem_ready),
        .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_stall(a_ides),
        .id_ex_flush(a_idef), .ex_mem_stall(a_ems), .mem_wb_bubble(a_mwb), .stall(a_st),
        .mem_error(a_err)
    );

    hazard_controller #(.REG_W(3), .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dut3 (
        .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .mem_op(mem_op), .mem_ready(mem_ready),
        .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_stall(b_ides),
        .id_ex_flush(b_idef), .ex_mem_stall(b_ems), .mem_wb_bubble(b_mwb), .stall(b_st),
        .mem_error(b_err)
    );

    assign d1 = {a_pc, a_ifs, a_iff, a_ides, a_idef, a_ems, a_mwb, a_st};
    assign d3 = {b_pc, b_ifs, b_iff, b_ides, b_idef, b_ems, b_mwb, b_st};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-14s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        id_opcode       = 4'd1;
        id_rs           = 3'd1;
        id_rt           = 3'd1;
        ex_mem_to_reg   = 1'b0;
        ex_write_reg    = 3'd0;
        ex_branch_taken = 1'b0;
        mem_op          = 2'b00;
        mem_ready       = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs for that cycle are then driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        settle();
        chk("rst_d1", d1, IDLE);
        chk("rst_d3", d3, IDLE);
        chk("rst_err", {7'd0, a_err}, 8'd0);
        tick();
        reset_n = 1'b1;

        // Load-use on rt, single bubble.
        tick();
        id_opcode = 4'd0; id_rs = 3'd1; id_rt = 3'd2;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd2;
        settle();
        chk("t1_stall", d1, LSTALL);
        tick();
        ex_mem_to_reg = 1'b0;
        settle();
        chk("t1_after", d1, IDLE);
        do_reset();
        id_opcode = 4'd0; id_rs = 3'd1; id_rt = 3'd0;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd0;
        settle();
        chk("t1_r0_d1", d1, IDLE);
        chk("t1_r0_d3", d3, IDLE);

        // Three-bubble load-use on rs.
        do_reset();
        id_opcode = 4'd1; id_rs = 3'd3; id_rt = 3'd5;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd3;
        settle();
        chk("t2_c1", d3, LSTALL);
        tick();
        ex_mem_to_reg = 1'b0;
        settle();
        chk("t2_c2", d3, LSTALL);
        chk("t2_c2_d1", d1, IDLE);
        tick();
        settle();
        chk("t2_c3", d3, LSTALL);
        tick();
        settle();
        chk("t2_c4", d3, IDLE);
        id_opcode = 4'd1; id_rs = 3'd1; id_rt = 3'd4;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd4;
        settle();
        chk("t2_rt_only3", d3, IDLE);
        chk("t2_rt_only1", d1, IDLE);

        // Branch aborts LOAD_STALL.
        do_reset();
        id_opcode = 4'd0; id_rs = 3'd3; id_rt = 3'd6;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd3;
        settle();
        chk("t3_c1", d3, LSTALL);
        tick();
        ex_mem_to_reg = 1'b0; ex_branch_taken = 1'b1;
        settle();
        chk("t3_br", d3, FLUSH2);
        tick();
        ex_branch_taken = 1'b0;
        settle();
        chk("t3_run", d3, IDLE);

        // Memory read wait overrides a taken branch.
        do_reset();
        mem_op = 2'b01; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t4_frz%0d", i), d1, FREEZE);
            tick();
        end
        mem_ready = 1'b1; ex_branch_taken = 1'b0;
        settle();
        chk("t4_ready", d1, IDLE);
        chk("t4_d3", d3, IDLE);
        chk("t4_err", {7'd0, a_err}, 8'd0);

        // Write wait stuck low: watchdog releases on cycle 16.
        do_reset();
        mem_op = 2'b10; mem_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            settle();
            chk($sformatf("t5_frz%0d", i), d1, FREEZE);
            tick();
        end
        settle();
        chk("t5_release", d1, IDLE);
        chk("t5_err16", {7'd0, a_err}, 8'd0);
        tick();
        mem_op = 2'b00;
        settle();
        chk("t5_err17", {7'd0, a_err}, 8'd1);
        chk("t5_err17b", {7'd0, b_err}, 8'd1);
        tick();
        tick();
        settle();
        chk("t5_sticky", {7'd0, a_err}, 8'd1);
        reset_n = 1'b0;
        settle();
        chk("t5_err_rst", {7'd0, a_err}, 8'd0);
        tick();
        reset_n = 1'b1;

        // Async reset in the middle of LOAD_STALL, then a fresh hazard.
        id_opcode = 4'd2; id_rs = 3'd7; id_rt = 3'd5;
        ex_mem_to_reg = 1'b1; ex_write_reg = 3'd5;
        settle();
        chk("t6_c1", d3, LSTALL);
        tick();
        ex_mem_to_reg = 1'b0;
        settle();
        chk("t6_c2", d3, LSTALL);
        reset_n = 1'b0;
        settle();
        chk("t6_async", d3, IDLE);
        tick();
        reset_n = 1'b1;
        ex_mem_to_reg = 1'b1;
        settle();
        chk("t6_f1", d3, LSTALL);
        tick();
        ex_mem_to_reg = 1'b0;
        settle();
        chk("t6_f2", d3, LSTALL);
        tick();
        settle();
        chk("t6_f3", d3, LSTALL);
        tick();
        settle();
        chk("t6_f4", d3, IDLE);
        id_opcode = 4'd15; id_rs = 3'd5; id_rt = 3'd5;
        settle();
        chk("t6_jump", d1, JUMP);
        tick();
        id_opcode = 4'd0;
        settle();
        chk("t6_jump_end", d1, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
